// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: RV32 fetch PC, 1-cycle imem requests and FWFT decode queue; IFETCH_MISALIGN_CHECK_EN adds misaligned-redirect fault
module instr_fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   imem_req,
    output logic [31:0]            imem_addr,
    input  logic [31:0]            imem_out,
    input  logic                   redirect_valid,
    input  logic [31:0]            redirect_pc,
    output logic                   dec_valid,
    input  logic                   dec_ready,
    output logic [31:0]            dec_instr,
    output logic [31:0]            dec_pc,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   fetch_fault
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

    logic [31:0]   fetch_pc_q, req_pc_q;
    logic          inflight_q;
    logic [AW-1:0] rd_q, wr_q;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   pc_mem [DEPTH];
    logic [31:0]   instr_mem [DEPTH];
    logic          pop, fault_hold;
    logic [CW:0]   occ;

    always_comb begin
        pop       = dec_valid & dec_ready;
        occ       = {1'b0, count_q} + (CW+1)'(inflight_q) - (CW+1)'(pop);
        imem_req  = !rst & !redirect_valid & !fault_hold & (occ < DEPTH_W);
        count_d   = count_q + CW'(inflight_q) - CW'(pop);
        dec_valid = count_q != '0;
        dec_instr = dec_valid ? instr_mem[rd_q] : 32'h0;
        dec_pc    = dec_valid ? pc_mem[rd_q] : 32'h0;
    end

    assign imem_addr  = fetch_pc_q;
    assign fifo_count = count_q;

    // Credit check above means a returning response always has a free slot
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            inflight_q <= 1'b0;
            rd_q       <= '0;
            wr_q       <= '0;
            count_q    <= '0;
        end else if (redirect_valid) begin
            fetch_pc_q <= {redirect_pc[31:2], 2'b00};
            inflight_q <= 1'b0;
            rd_q       <= '0;
            wr_q       <= '0;
            count_q    <= '0;
        end else begin
            inflight_q <= imem_req;
            if (imem_req) begin
                fetch_pc_q <= fetch_pc_q + 32'd4;
                req_pc_q   <= fetch_pc_q;
            end
            if (inflight_q) begin
                pc_mem[wr_q]    <= req_pc_q;
                instr_mem[wr_q] <= imem_out;
                wr_q            <= wr_q + AW'(1);
            end
            if (pop) rd_q <= rd_q + AW'(1);
            count_q <= count_d;
        end
    end

`ifdef IFETCH_MISALIGN_CHECK_EN
    logic fault_q;
    always_ff @(posedge clk) begin
        if (rst) fault_q <= 1'b0;
        else if (redirect_valid) fault_q <= redirect_pc[1:0] != 2'b00;
    end
    assign fault_hold  = fault_q;
    assign fetch_fault = fault_q;
`else
    logic unused_low_bits;
    assign unused_low_bits = ^redirect_pc[1:0];
    assign fault_hold      = 1'b0;
    assign fetch_fault     = 1'b0;
`endif
endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb_instr_fetch_queue: table, directed and random checks of instr_fetch_queue against a queue-based reference model
module tb_instr_fetch_queue;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0, rst = 1'b0, redirect_valid = 1'b0, dec_ready = 1'b0;
    logic        imem_req, dec_valid, fetch_fault;
    logic [31:0] imem_addr, dec_instr, dec_pc;
    logic [31:0] imem_out = 32'h0, redirect_pc = 32'h0;
    logic [2:0]  fifo_count;

    int n_chk = 0, n_fail = 0;

    logic        s_req, s_vld, s_fault;
    logic [31:0] s_addr, s_pc, s_instr;
    logic [2:0]  s_cnt;

    bit          m_init = 0, m_pend = 0, m_fault = 0;
    logic [31:0] m_pc = 32'h0, m_pend_pc = 32'h0;
    logic [31:0] mq[$];

    typedef struct {
        logic        rdy;
        logic        req;
        logic [31:0] addr;
        logic        vld;
        logic [31:0] pc;
        logic [2:0]  cnt;
    } vec_t;
    vec_t tv[6];

    instr_fetch_queue #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_out(imem_out), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_instr(dec_instr),
        .dec_pc(dec_pc), .fifo_count(fifo_count), .fetch_fault(fetch_fault)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h7d00_8093;
    endfunction

    // Synchronous instruction memory: data for the address presented this cycle appears next cycle
    always @(posedge clk) imem_out <= mem_f(imem_addr);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input bit r, input bit rv, input logic [31:0] rpc, input bit rdy);
        bit          pop, e_req;
        int          occ;
        logic [31:0] head;
        rst = r; redirect_valid = rv; redirect_pc = rpc; dec_ready = rdy;
        @(negedge clk);
        s_req = imem_req; s_addr = imem_addr; s_vld = dec_valid; s_pc = dec_pc;
        s_instr = dec_instr; s_cnt = fifo_count; s_fault = fetch_fault;
        pop   = (mq.size() != 0) && rdy;
        occ   = mq.size() + int'(m_pend) - int'(pop);
        e_req = !r && !rv && !m_fault && (occ < DEPTH);
        if (mq.size() != 0) head = mq[0]; else head = 32'h0;
        chk("imem_req", 32'(s_req), 32'(e_req));
        if (m_init) begin
            chk("imem_addr", s_addr, m_pc);
            chk("dec_valid", 32'(s_vld), 32'(mq.size() != 0));
            chk("fifo_count", 32'(s_cnt), 32'(mq.size()));
            chk("dec_pc", s_pc, head);
            chk("dec_instr", s_instr, (mq.size() != 0) ? mem_f(head) : 32'h0);
            chk("fetch_fault", 32'(s_fault), 32'(m_fault));
        end
        if (r) begin
            m_init = 1; m_pc = RESET_PC; m_pend = 0; m_fault = 0; mq.delete();
        end else if (m_init && rv) begin
            mq.delete();
            m_pend = 0;
            m_pc = {rpc[31:2], 2'b00};
`ifdef IFETCH_MISALIGN_CHECK_EN
            m_fault = rpc[1:0] != 2'b00;
`endif
        end else if (m_init) begin
            if (pop) void'(mq.pop_front());
            if (m_pend) mq.push_back(m_pend_pc);
            m_pend = e_req;
            if (e_req) begin
                m_pend_pc = m_pc;
                m_pc = m_pc + 32'd4;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] v;
        tv[0] = '{1'b1, 1'b1, 32'h00, 1'b0, 32'h0, 3'd0};
        tv[1] = '{1'b1, 1'b1, 32'h04, 1'b0, 32'h0, 3'd0};
        tv[2] = '{1'b1, 1'b1, 32'h08, 1'b1, 32'h0, 3'd1};
        tv[3] = '{1'b1, 1'b1, 32'h0C, 1'b1, 32'h4, 3'd1};
        tv[4] = '{1'b1, 1'b1, 32'h10, 1'b1, 32'h8, 3'd1};
        tv[5] = '{1'b1, 1'b1, 32'h14, 1'b1, 32'hC, 3'd1};

        step(1, 0, 0, 1);
        step(1, 0, 0, 1);
        chk("rst_req", 32'(s_req), 32'h0);
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 0, tv[i].rdy);
            chk("tbl_req", 32'(s_req), 32'(tv[i].req));
            chk("tbl_addr", s_addr, tv[i].addr);
            chk("tbl_vld", 32'(s_vld), 32'(tv[i].vld));
            chk("tbl_pc", s_pc, tv[i].pc);
            chk("tbl_cnt", 32'(s_cnt), 32'(tv[i].cnt));
            chk("tbl_instr", s_instr, tv[i].vld ? mem_f(tv[i].pc) : 32'h0);
            chk("tbl_fault", 32'(s_fault), 32'h0);
        end

        for (int i = 0; i < 10; i++) step(0, 0, 0, 0);
        chk("stall_cnt", 32'(s_cnt), 32'd4);
        chk("stall_req", 32'(s_req), 32'h0);
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 0, 1);
            chk("resume_vld", 32'(s_vld), 32'h1);
            chk("resume_pc", s_pc, 32'h10 + 32'(4 * i));
        end

        step(0, 1, 32'h0000_302C, 1);
        chk("redir_req", 32'(s_req), 32'h0);
        step(0, 0, 0, 1);
        chk("redir_cnt", 32'(s_cnt), 32'h0);
        chk("redir_addr", s_addr, 32'h302C);
        chk("redir_req1", 32'(s_req), 32'h1);
        step(0, 0, 0, 1);
        chk("redir_vld2", 32'(s_vld), 32'h0);
        step(0, 0, 0, 1);
        chk("redir_vld3", 32'(s_vld), 32'h1);
        chk("redir_pc", s_pc, 32'h302C);

        step(0, 1, 32'h100, 1);
        step(0, 1, 32'h200, 1);
        step(0, 0, 0, 1);
        chk("b2b_addr", s_addr, 32'h200);
        chk("b2b_cnt", 32'(s_cnt), 32'h0);
        step(0, 0, 0, 1);
        chk("b2b_vld", 32'(s_vld), 32'h0);
        step(0, 0, 0, 1);
        chk("b2b_pc", s_pc, 32'h200);
        chk("b2b_vld3", 32'(s_vld), 32'h1);

        step(0, 1, 32'h0000_302E, 1);
`ifdef IFETCH_MISALIGN_CHECK_EN
        step(0, 0, 0, 1);
        chk("mis_fault", 32'(s_fault), 32'h1);
        chk("mis_cnt", 32'(s_cnt), 32'h0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 1);
            chk("mis_req", 32'(s_req), 32'h0);
        end
        step(0, 1, 32'h0000_3030, 1);
        step(0, 0, 0, 1);
        chk("mis_clr", 32'(s_fault), 32'h0);
        chk("mis_addr", s_addr, 32'h3030);
        chk("mis_req1", 32'(s_req), 32'h1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        chk("mis_pc", s_pc, 32'h3030);
`else
        step(0, 0, 0, 1);
        chk("mis_fault", 32'(s_fault), 32'h0);
        chk("mis_addr", s_addr, 32'h302C);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        chk("mis_pc", s_pc, 32'h302C);
`endif

        for (int i = 0; i < 8; i++) step(0, 0, 0, 0);
        chk("full_cnt", 32'(s_cnt), 32'd4);
        step(0, 0, 0, 1);
        chk("full_pop_req", 32'(s_req), 32'h1);
        step(1, 0, 0, 0);
        chk("mrst_req", 32'(s_req), 32'h0);
        step(0, 0, 0, 0);
        chk("mrst_cnt", 32'(s_cnt), 32'h0);
        chk("mrst_vld", 32'(s_vld), 32'h0);
        chk("mrst_addr", s_addr, RESET_PC);
        step(0, 0, 0, 0);
        chk("mrst_drop", 32'(s_vld), 32'h0);
        step(0, 0, 0, 1);
        chk("mrst_pc", s_pc, RESET_PC);

        step(0, 1, 32'hFFFF_FFF8, 1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        chk("wrap_addr", s_addr, 32'h0);

        for (int i = 0; i < 3000; i++) begin
            v = $urandom;
            if ($urandom_range(0, 3) != 0) v[1:0] = 2'b00;
            if ($urandom_range(0, 7) == 0) v[31:8] = 24'hFFFFFF;
            step($urandom_range(0, 299) == 0, $urandom_range(0, 11) == 0, v,
                 $urandom_range(0, 3) != 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
